// File: rtl/normalizador_seq.sv
// normalizador_seq: scales signed Q9.23 by unsigned Q6.26 K_CONST into saturated signed Q2.30 via a serial shift-add multiplier (optional NORMALIZADOR_ROUND_EN)
module normalizador_seq #(
    parameter logic [31:0] K_CONST = 32'h0400_0000,
    parameter int          W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
    state_t state, state_nx;
    logic        sign;
    logic [31:0] mag;
    logic [63:0] acc, acc_nx;
    logic [4:0]  cnt;
    logic [32:0] m;
    logic        big, sat;
    logic [31:0] y_nx;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // next state and result formatting from the accumulator including this cycle's term
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (in_valid && in_ready) ? MULT : IDLE;
            MULT:    state_nx = (cnt == 5'd31) ? DONE : MULT;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        acc_nx = acc + (K_CONST[cnt] ? ({32'd0, mag} << cnt) : 64'd0);
`ifdef NORMALIZADOR_ROUND_EN
        m = {1'b0, acc_nx[50:19]} + {32'd0, acc_nx[18]};
`else
        m = {1'b0, acc_nx[50:19]};
`endif
        big = |acc_nx[63:51];
        sat = big || (sign ? (m > 33'h0_8000_0000) : (m >= 33'h0_8000_0000));
        y_nx = sat ? (sign ? 32'h8000_0000 : 32'h7FFF_FFFF) : (sign ? -m[31:0] : m[31:0]);
    end
    // operand capture, serial accumulation and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            sign     <= 1'b0;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            y        <= '0;
            ovf      <= 1'b0;
        end else begin
            in_ready <= (state_nx == IDLE);
            if (state == IDLE && in_valid && in_ready) begin
                sign <= a[31];
                mag  <= a[31] ? -a : a;
                acc  <= '0;
                cnt  <= '0;
            end
            if (state == MULT) begin
                acc <= acc_nx;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    y   <= y_nx;
                    ovf <= sat;
                end
            end
        end
    end
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_normalizador_seq.sv
// tb_normalizador_seq: directed vectors for normalizador_seq, default K plus a small-K rounding instance
module tb_normalizador_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0;
    logic        in_ready, out_valid, ovf;
    logic [31:0] y;
    logic        iv2 = 1'b0, or2 = 1'b0;
    logic [31:0] a2 = '0;
    logic        ir2, ov2, ovf2;
    logic [31:0] y2;
    int checks = 0, errors = 0;

    normalizador_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );
    normalizador_seq #(.K_CONST(32'h0004_0000)) dut_k (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2),
        .out_valid(ov2), .out_ready(or2), .y(y2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] ey,
                       input logic eo, input int hold);
        int t, lat;
        a = av;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk({tag, "_accept_to"}, 32'(t < 100), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'h0100_0000;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'd33);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_y"}, y, ey);
            chk({tag, "_hold_ovf"}, {31'd0, ovf}, {31'd0, eo});
            chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        run("one",      32'h0080_0000, 32'h4000_0000, 1'b0, 0);
        run("mhalf",    32'hFFC0_0000, 32'hE000_0000, 1'b0, 0);
        run("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        run("two",      32'h0100_0000, 32'h7FFF_FFFF, 1'b1, 0);
        run("mtwo",     32'hFF00_0000, 32'h8000_0000, 1'b0, 0);
        run("mtwo_lsb", 32'hFEFF_FFFF, 32'h8000_0000, 1'b1, 0);
        run("minint",   32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        run("maxint",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);
        run("lsb",      32'h0000_0001, 32'h0000_0080, 1'b0, 0);
        run("mlsb",     32'hFFFF_FFFF, 32'hFFFF_FF80, 1'b0, 0);
        run("half_hold",32'h0040_0000, 32'h2000_0000, 1'b0, 10);
        run("after",    32'hFFC0_0000, 32'hE000_0000, 1'b0, 0);
        a = 32'h0080_0000;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("abort_ready_back", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("abort_no_out", {31'd0, out_valid}, 32'd0);
        run("one_again", 32'h0080_0000, 32'h4000_0000, 1'b0, 0);
        chk("k_ready", {31'd0, ir2}, 32'd1);
        a2 = 32'h0000_0001;
        iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        t = 1;
        while (!ov2 && t < 100) begin @(negedge clk); t++; end
        chk("k_lat", 32'(t), 32'd33);
`ifdef NORMALIZADOR_ROUND_EN
        chk("k_y", y2, 32'h0000_0001);
`else
        chk("k_y", y2, 32'h0000_0000);
`endif
        chk("k_ovf", {31'd0, ovf2}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
